// File: rtl/rx_pkt_buf.sv
// rx_pkt_buf -- store-and-forward receive packet buffer.
//
// Bytes from the LLC receive side are written into a 2^AW x 8 circular RAM.
// A packet only becomes visible to the reader once its eop byte has been
// accepted (commit). Packets that overflow the RAM, exceed the maximum
// length, find the length FIFO full at eop, or are cut short by a new sop
// are rolled back and counted in drop_cnt. The reader requests one whole
// packet at a time and receives it as a contiguous sop..eop byte stream.
//
// Ports
//   clk_125m, rst_125m      : clock, asynchronous active-high reset
//   llcrx_rxfifo_data/dval  : write byte and its valid
//   llcrx_rxfifo_sop/eop    : packet delimiters, qualified by dval
//   pkt_rd_req              : one-cycle request to read one packet
//   pkt_rdy                 : a committed packet is waiting and reader is idle
//   rxfifo_data/dval/sop/eop: read byte stream
//   pkt_num                 : committed packets not yet read
//   drop_cnt                : saturating count of dropped packets
//   frame_err               : one-cycle pulse on a protocol error
module rx_pkt_buf #(
    parameter int AW = 11,
    parameter int LW = 3
) (
    input  logic          clk_125m,
    input  logic          rst_125m,
    input  logic [7:0]    llcrx_rxfifo_data,
    input  logic          llcrx_rxfifo_dval,
    input  logic          llcrx_rxfifo_sop,
    input  logic          llcrx_rxfifo_eop,
    input  logic          pkt_rd_req,
    output logic          pkt_rdy,
    output logic [7:0]    rxfifo_data,
    output logic          rxfifo_dval,
    output logic          rxfifo_sop,
    output logic          rxfifo_eop,
    output logic [LW:0]   pkt_num,
    output logic [15:0]   drop_cnt,
    output logic          frame_err
);

    typedef enum logic [1:0] {IDLE, RECV, DROP} wstate_t;
    typedef enum logic [1:0] {RIDLE, RLOAD, RSEND} rstate_t;

    localparam logic [AW:0]   FULL_OCC = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] LEN_MAX  = {AW{1'b1}};
    localparam logic [AW-1:0] LEN_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW:0]   LF_FULL  = {1'b1, {LW{1'b0}}};

    // Storage (no reset: contents are only meaningful behind the pointers)
    logic [7:0]    mem_q    [0:(1<<AW)-1];
    logic [AW-1:0] lf_mem_q [0:(1<<LW)-1];

    // Write side state
    wstate_t     wstate_q, wstate_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] wr_commit_q, wr_commit_d;
    logic [AW-1:0] len_q, len_d;
    logic [15:0] drop_cnt_q;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  drop_inc;
    logic        mem_we;
    logic [AW-1:0] mem_waddr;
    logic        lf_push;
    logic [AW-1:0] lf_push_len;

    // Length FIFO pointers (LW+1 bits with wrap bit)
    logic [LW:0] lf_wr_q, lf_rd_q;
    logic        lf_pop;
    logic        lf_full;

    // Read side state
    rstate_t     rstate_q, rstate_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic        rd_en;
    logic        out_dval_d, out_sop_d, out_eop_d;
    logic [7:0]  out_data_q;
    logic        out_dval_q, out_sop_q, out_eop_q;

    logic [AW:0] occ_wr, occ_base;

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign pkt_num  = lf_wr_q - lf_rd_q;
    assign lf_full  = (pkt_num == LF_FULL);
    assign pkt_rdy  = (pkt_num != '0) && (rstate_q == RIDLE);
    assign occ_wr   = wr_ptr_q - rd_ptr_q;
    // Occupancy seen by a packet restarting at the last commit point
    assign occ_base = wr_commit_q - rd_ptr_q;

    assign rxfifo_data = out_data_q;
    assign rxfifo_dval = out_dval_q;
    assign rxfifo_sop  = out_sop_q;
    assign rxfifo_eop  = out_eop_q;
    assign drop_cnt    = drop_cnt_q;
    assign frame_err   = frame_err_q;

    // Write FSM. Outside RECV wr_ptr always equals wr_commit, so every new
    // packet (from IDLE, DROP, or a sop that aborts RECV) starts at wr_commit.
    always_comb begin
        wstate_d    = wstate_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        len_d       = len_q;
        drop_inc    = 2'd0;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q[AW-1:0];
        lf_push     = 1'b0;
        lf_push_len = len_q;
        if (llcrx_rxfifo_dval) begin
            if (llcrx_rxfifo_sop) begin
                if (wstate_q == RECV) begin
                    drop_inc    = 2'd1;
                    frame_err_d = 1'b1;
                end
                wr_ptr_d = wr_commit_q;
                if (occ_base == FULL_OCC) begin
                    drop_inc = drop_inc + 2'd1;
                    wstate_d = llcrx_rxfifo_eop ? IDLE : DROP;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_commit_q[AW-1:0];
                    wr_ptr_d  = wr_commit_q + 1'b1;
                    len_d     = LEN_ONE;
                    if (llcrx_rxfifo_eop) begin
                        wstate_d = IDLE;
                        if (lf_full) begin
                            drop_inc = drop_inc + 2'd1;
                            wr_ptr_d = wr_commit_q;
                        end else begin
                            wr_commit_d = wr_commit_q + 1'b1;
                            lf_push     = 1'b1;
                            lf_push_len = LEN_ONE;
                        end
                    end else begin
                        wstate_d = RECV;
                    end
                end
            end else begin
                case (wstate_q)
                    IDLE: frame_err_d = 1'b1;
                    RECV: begin
                        // RAM full or packet would exceed LEN_MAX bytes
                        if (occ_wr == FULL_OCC || len_q == LEN_MAX) begin
                            drop_inc = 2'd1;
                            wr_ptr_d = wr_commit_q;
                            wstate_d = llcrx_rxfifo_eop ? IDLE : DROP;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = wr_ptr_q[AW-1:0];
                            wr_ptr_d  = wr_ptr_q + 1'b1;
                            len_d     = len_q + 1'b1;
                            if (llcrx_rxfifo_eop) begin
                                wstate_d = IDLE;
                                if (lf_full) begin
                                    drop_inc = 2'd1;
                                    wr_ptr_d = wr_commit_q;
                                end else begin
                                    wr_commit_d = wr_ptr_q + 1'b1;
                                    lf_push     = 1'b1;
                                    lf_push_len = len_q + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        if (llcrx_rxfifo_eop) wstate_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Read FSM. RLOAD issues the first RAM read so the sop byte appears two
    // cycles after the accepted request; RSEND stays until the eop byte has
    // been shown, so pkt_rdy cannot rise while eop is still on the outputs.
    always_comb begin
        rstate_d   = rstate_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        lf_pop     = 1'b0;
        rd_en      = 1'b0;
        out_dval_d = 1'b0;
        out_sop_d  = 1'b0;
        out_eop_d  = 1'b0;
        case (rstate_q)
            RIDLE: begin
                if (pkt_rd_req && pkt_rdy) begin
                    lf_pop   = 1'b1;
                    cnt_d    = lf_mem_q[lf_rd_q[LW-1:0]];
                    rstate_d = RLOAD;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    rd_en      = 1'b1;
                    out_dval_d = 1'b1;
                    out_sop_d  = (rstate_q == RLOAD);
                    out_eop_d  = (cnt_q == LEN_ONE);
                    cnt_d      = cnt_q - 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    rstate_d   = RSEND;
                end else begin
                    rstate_d = RIDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_125m or posedge rst_125m) begin
        if (rst_125m) begin
            wstate_q    <= IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            len_q       <= '0;
            drop_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            lf_wr_q     <= '0;
            lf_rd_q     <= '0;
            rstate_q    <= RIDLE;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_data_q  <= 8'h00;
            out_dval_q  <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            len_q       <= len_d;
            drop_cnt_q  <= sat_add(drop_cnt_q, drop_inc);
            frame_err_q <= frame_err_d;
            if (lf_push) lf_wr_q <= lf_wr_q + 1'b1;
            if (lf_pop)  lf_rd_q <= lf_rd_q + 1'b1;
            rstate_q    <= rstate_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            if (rd_en) out_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            out_dval_q  <= out_dval_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    always_ff @(posedge clk_125m) begin
        if (mem_we)  mem_q[mem_waddr] <= llcrx_rxfifo_data;
        if (lf_push) lf_mem_q[lf_wr_q[LW-1:0]] <= lf_push_len;
    end

endmodule

// File: tb/tb_rx_pkt_buf.sv
// Testbench for rx_pkt_buf: directed packet writes, reads checked byte by
// byte through an expected-byte queue drained by an independent monitor.
module tb_rx_pkt_buf;

    logic        clk_125m = 1'b0;
    logic        rst_125m = 1'b1;
    logic [7:0]  llcrx_rxfifo_data = 8'h00;
    logic        llcrx_rxfifo_dval = 1'b0;
    logic        llcrx_rxfifo_sop  = 1'b0;
    logic        llcrx_rxfifo_eop  = 1'b0;
    logic        pkt_rd_req = 1'b0;
    logic        pkt_rdy;
    logic [7:0]  rxfifo_data;
    logic        rxfifo_dval, rxfifo_sop, rxfifo_eop;
    logic [3:0]  pkt_num;
    logic [15:0] drop_cnt;
    logic        frame_err;

    rx_pkt_buf #(.AW(11), .LW(3)) dut (
        .clk_125m(clk_125m), .rst_125m(rst_125m),
        .llcrx_rxfifo_data(llcrx_rxfifo_data), .llcrx_rxfifo_dval(llcrx_rxfifo_dval),
        .llcrx_rxfifo_sop(llcrx_rxfifo_sop), .llcrx_rxfifo_eop(llcrx_rxfifo_eop),
        .pkt_rd_req(pkt_rd_req), .pkt_rdy(pkt_rdy),
        .rxfifo_data(rxfifo_data), .rxfifo_dval(rxfifo_dval),
        .rxfifo_sop(rxfifo_sop), .rxfifo_eop(rxfifo_eop),
        .pkt_num(pkt_num), .drop_cnt(drop_cnt), .frame_err(frame_err)
    );

    always #4 clk_125m = ~clk_125m;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } exp_t;

    typedef struct {
        logic [7:0] seed;
        int         len;
    } pkt_t;

    exp_t sb[$];     // expected output bytes, in order
    pkt_t model[$];  // packets expected to be committed, in order

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented byte must match the head of the scoreboard
    always @(negedge clk_125m) begin
        if (!rst_125m && rxfifo_dval) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_byte: got %0h, expected no byte", rxfifo_data);
            end else begin
                exp_t e;
                exp_t g;
                e = sb.pop_front();
                g = '{d: rxfifo_data, s: rxfifo_sop, e: rxfifo_eop};
                check("rd_byte{data,sop,eop}", 32'(g), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk_125m);
        #1;
    endtask

    task automatic wr_idle();
        llcrx_rxfifo_dval = 1'b0;
        llcrx_rxfifo_sop  = 1'b0;
        llcrx_rxfifo_eop  = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic s, input logic e);
        llcrx_rxfifo_data = d;
        llcrx_rxfifo_dval = 1'b1;
        llcrx_rxfifo_sop  = s;
        llcrx_rxfifo_eop  = e;
        tick();
    endtask

    // Byte i of a packet is seed+i
    task automatic wr_pkt(input logic [7:0] seed, input int len, input bit commit);
        for (int i = 0; i < len; i++)
            wr_byte(seed + 8'(i), i == 0, i == len - 1);
        wr_idle();
        if (commit) model.push_back('{seed: seed, len: len});
    endtask

    task automatic do_reset();
        wr_idle();
        pkt_rd_req = 1'b0;
        rst_125m = 1'b1;
        tick(); tick();
        rst_125m = 1'b0;
        sb.delete();
        model.delete();
        tick();
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!pkt_rdy && n < 5000) begin
            tick();
            n++;
        end
        check("pkt_rdy_wait", 32'(pkt_rdy), 32'd1);
    endtask

    // Accept one read and load its expected bytes; checks the 2-cycle latency
    task automatic issue_read();
        pkt_t p;
        if (model.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_model: got empty model, expected a committed packet");
            return;
        end
        pkt_rd_req = 1'b1;
        tick();
        pkt_rd_req = 1'b0;
        p = model.pop_front();
        for (int i = 0; i < p.len; i++)
            sb.push_back('{d: p.seed + 8'(i), s: (i == 0), e: (i == p.len - 1)});
        @(negedge clk_125m);
        check("latency_cycle1_dval", 32'(rxfifo_dval), 32'd0);
        @(negedge clk_125m);
        check("latency_cycle2_dval_sop", {30'd0, rxfifo_dval, rxfifo_sop}, 32'd3);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk_125m);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic rd_pkt();
        wait_rdy();
        issue_read();
        wait_empty();
    endtask

    initial begin
        #700us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_pkt_num", 32'(pkt_num), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_pkt_rdy", 32'(pkt_rdy), 32'd0);
        check("rst_outputs", {rxfifo_data, rxfifo_dval, rxfifo_sop, rxfifo_eop, frame_err}, 32'd0);
        rst_125m = 1'b0;
        tick();

        // 6-byte packet 01..06
        wr_pkt(8'h01, 6, 1);
        check("t1_pkt_num", 32'(pkt_num), 32'd1);
        check("t1_pkt_rdy", 32'(pkt_rdy), 32'd1);
        rd_pkt();
        check("t1_pkt_num_after", 32'(pkt_num), 32'd0);
        check("t1_pkt_rdy_after", 32'(pkt_rdy), 32'd0);

        // Fill the length FIFO, 9th packet dropped
        for (int k = 0; k < 8; k++) wr_pkt(8'(k * 16), 3 + k, 1);
        check("t2_pkt_num_full", 32'(pkt_num), 32'd8);
        wr_pkt(8'hF0, 5, 0);
        check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t2_pkt_num_after_drop", 32'(pkt_num), 32'd8);
        for (int k = 0; k < 8; k++) rd_pkt();
        check("t2_pkt_num_empty", 32'(pkt_num), 32'd0);

        // Over-length packet then a normal one
        do_reset();
        wr_pkt(8'h40, 2049, 0);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t3_pkt_num", 32'(pkt_num), 32'd0);
        check("t3_ptrs", {8'd0, dut.wr_ptr_q, dut.wr_commit_q}, 32'd0);
        wr_pkt(8'hA0, 4, 1);
        check("t3_pkt_num_4b", 32'(pkt_num), 32'd1);
        rd_pkt();

        // sop inside an open packet, then a stray byte in IDLE
        do_reset();
        wr_byte(8'h11, 1'b1, 1'b0);
        wr_byte(8'h12, 1'b0, 1'b0);
        wr_byte(8'h21, 1'b1, 1'b0);
        check("t4_frame_err_pulse", 32'(frame_err), 32'd1);
        check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
        wr_byte(8'h22, 1'b0, 1'b0);
        check("t4_frame_err_clear", 32'(frame_err), 32'd0);
        wr_byte(8'h23, 1'b0, 1'b1);
        wr_idle();
        model.push_back('{seed: 8'h21, len: 3});
        check("t4_pkt_num", 32'(pkt_num), 32'd1);
        wr_byte(8'h55, 1'b0, 1'b0);
        wr_idle();
        check("t4_stray_frame_err", 32'(frame_err), 32'd1);
        tick();
        check("t4_stray_pkt_num", 32'(pkt_num), 32'd1);
        check("t4_stray_drop_cnt", 32'(drop_cnt), 32'd1);
        rd_pkt();
        check("t4_pkt_num_after", 32'(pkt_num), 32'd0);

        // Concurrent 1000-byte packets crossing the RAM wrap point
        do_reset();
        fork
            begin
                for (int k = 0; k < 5; k++) wr_pkt(8'(k * 7 + 3), 1000, 1);
            end
            begin
                for (int k = 0; k < 5; k++) rd_pkt();
            end
        join
        check("t5_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t5_pkt_num", 32'(pkt_num), 32'd0);

        // Reset during a read
        do_reset();
        wr_pkt(8'h30, 20, 1);
        wait_rdy();
        issue_read();
        tick(); tick(); tick();
        #2 rst_125m = 1'b1;
        #1;
        check("t6_outputs_in_reset", {rxfifo_data, rxfifo_dval, rxfifo_sop, rxfifo_eop}, 32'd0);
        sb.delete();
        model.delete();
        tick();
        rst_125m = 1'b0;
        tick();
        check("t6_pkt_num", 32'(pkt_num), 32'd0);
        check("t6_pkt_rdy", 32'(pkt_rdy), 32'd0);
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_pkt_buf.md
RX_PKT_BUF -- requirements
Module: rx_pkt_buf

Interface
REQ-001 SHALL have parameter AW, default 11, meaning byte-buffer address width (depth 2^AW = 2048 bytes).
REQ-002 SHALL have parameter LW, default 3, meaning length-FIFO address width (8 packet descriptors).
REQ-003 SHALL have port clk_125m  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_125m  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port llcrx_rxfifo_data  input  8  write byte.
REQ-006 SHALL have port llcrx_rxfifo_dval  input  1  write byte valid.
REQ-007 SHALL have port llcrx_rxfifo_sop  input  1  first byte of packet, qualified by dval.
REQ-008 SHALL have port llcrx_rxfifo_eop  input  1  last byte of packet, qualified by dval.
REQ-009 SHALL have port pkt_rd_req  input  1  single-cycle request to read one whole packet.
REQ-010 SHALL have port pkt_rdy  output  1  at least one committed packet stored and read side idle.
REQ-011 SHALL have port rxfifo_data  output  8  read byte.
REQ-012 SHALL have port rxfifo_dval  output  1  read byte valid.
REQ-013 SHALL have port rxfifo_sop  output  1  first read byte.
REQ-014 SHALL have port rxfifo_eop  output  1  last read byte.
REQ-015 SHALL have port pkt_num  output  LW+1  committed packets not yet read (0..8).
REQ-016 SHALL have port drop_cnt  output  16  dropped-packet count, saturating at 16'hFFFF.
REQ-017 SHALL have port frame_err  output  1  one-cycle pulse on protocol error (REQ-025, REQ-026).

Function
REQ-018 SHALL store bytes in a 2^AW x 8 RAM using AW+1-bit pointers (wrap bit) wr_ptr, wr_commit, rd_ptr; occupancy = wr_ptr - rd_ptr, modulo 2^(AW+1).
REQ-019 SHALL run write FSM IDLE/RECV/DROP: IDLE + dval&sop -> RECV (byte written, length = 1); RECV + dval -> byte written, length + 1; RECV + dval&eop -> commit, IDLE.
REQ-020 SHALL commit by setting wr_commit <= wr_ptr after the eop byte and pushing the 11-bit packet length into the length FIFO; pkt_num increments the next cycle.
REQ-021 SHALL, when a byte arrives with occupancy = 2^AW, or at eop with the length FIFO full, roll wr_ptr back to wr_commit, increment drop_cnt, and enter DROP (or IDLE if that byte is eop).
REQ-022 SHALL in DROP discard all bytes until dval&eop, then -> IDLE; dval&sop in DROP restarts RECV with that byte.
REQ-023 SHALL treat dval&sop&eop in IDLE as a 1-byte packet, committed in the same manner.
REQ-024 SHALL treat a packet longer than 2047 bytes as an overflow drop (REQ-021).
REQ-025 SHALL, on dval&sop while in RECV, roll back the open packet, increment drop_cnt, pulse frame_err, and start a new packet with that byte.
REQ-026 SHALL, on dval without sop in IDLE, discard the byte and pulse frame_err.
REQ-027 SHALL run read FSM RIDLE/RLOAD/RSEND: pkt_rdy = (pkt_num != 0) & RIDLE; pkt_rd_req & pkt_rdy pops the length FIFO -> RLOAD.
REQ-028 SHALL ignore pkt_rd_req when pkt_rdy = 0.
REQ-029 SHALL present the first byte with rxfifo_dval = rxfifo_sop = 1 exactly 2 cycles after the accepted pkt_rd_req, then one byte per cycle contiguously; rxfifo_eop = 1 on byte number "length"; -> RIDLE the following cycle.
REQ-030 SHALL hold rxfifo_sop/eop/dval at 0 when no byte is presented; rxfifo_data holds its last value.
REQ-031 SHALL advance rd_ptr per byte read; freed space is usable by a write on the following cycle.
REQ-032 SHALL update pkt_num correctly on simultaneous commit and pop (net unchanged).
REQ-033 SHALL operate the write and read sides concurrently, including RAM address wrap-around.

Reset
REQ-034 SHALL, while rst_125m = 1, force IDLE/RIDLE, all pointers 0, length FIFO empty, pkt_num = 0, drop_cnt = 0, pkt_rdy = 0, rxfifo_data = 8'h00, rxfifo_dval/sop/eop = 0, frame_err = 0.
REQ-035 SHALL abandon any packet in progress on either side when reset asserts mid-operation; no partial packet is output after release.

Verification
REQ-036 SHALL verify: write 6-byte packet 01..06 -> pkt_num = 1; pkt_rd_req -> bytes 01..06 begin 2 cycles later, sop on 01, eop on 06, pkt_num = 0.
REQ-037 SHALL verify: 8 packets written, no reads, 9th packet -> drop_cnt = 1, pkt_num = 8; all 8 read back intact.
REQ-038 SHALL verify: 2049-byte packet -> dropped, drop_cnt = 1, pointers unchanged, next 4-byte packet stored and read correctly.
REQ-039 SHALL verify: sop at byte 3 of an open packet -> frame_err pulse, drop_cnt = 1, only the second packet readable.
REQ-040 SHALL verify: continuous 1000-byte packets written while reading, crossing address 2047 -> 0 -> data intact, no drops.
REQ-041 SHALL verify: reset asserted mid-read -> outputs 0 immediately, pkt_num = 0 and pkt_rdy = 0 after release.
